// File: rtl/rsa_mem_pkg.sv
// Shared types and default sizes for the RSA operand RAM front ends.
// The stream FSM state encoding lives here so benches and tops agree on it.
package rsa_mem_pkg;

    localparam int OP_BYTES  = 128;
    localparam int RAM_WORDS = 129;
    localparam int BUS_W     = 32;
    localparam int MEM_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LD_ACCEPT,
        LD_WRITE,
        LD_GUARD,
        UL_READ,
        UL_WAIT,
        UL_OUT,
        DONE
    } stream_state_t;

endpackage

// File: rtl/int_ram_stream.sv
// Streams a 1024-bit operand between a 32-bit valid/ready bus and
// port 1 of the byte-wide operand RAM; the core must idle while busy.
module int_ram_stream
    import rsa_mem_pkg::*;
#(
    parameter int MEM_WIDTH = MEM_W,
    parameter int MEM_WORDS = RAM_WORDS,
    parameter int BUS_WIDTH = BUS_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_load,
    input  logic [BUS_WIDTH-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BUS_WIDTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MEM_WORDS)-1:0] ram_address,
    output logic [MEM_WIDTH-1:0]         ram_data,
    output logic                         ram_wren,
    output logic                         ram_rden,
    input  logic [MEM_WIDTH-1:0]         ram_q
);

    localparam int LANES = BUS_WIDTH / MEM_WIDTH;
    localparam int BEATS = (MEM_WORDS - 1) / LANES;
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [AW-1:0] GUARD_A   = AW'(MEM_WORDS - 1);

    if ((BUS_WIDTH % MEM_WIDTH) != 0 ||
        ((MEM_WORDS - 1) % LANES) != 0) begin : g_bad_cfg
        $error("int_ram_stream: bus/RAM geometry mismatch");
    end

    stream_state_t        state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [BUS_WIDTH-1:0] in_q, in_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 rd1_v_q, rd2_v_q;
    logic [LW-1:0]        rd1_lane_q, rd2_lane_q;
    logic [AW-1:0]        word_a;

    assign word_a   = AW'(int'(beat_q) * LANES + int'(lane_q));
    assign out_data = data_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            lane_q     <= '0;
            in_q       <= '0;
            data_q     <= '0;
            rd1_v_q    <= 1'b0;
            rd2_v_q    <= 1'b0;
            rd1_lane_q <= '0;
            rd2_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            lane_q     <= lane_d;
            in_q       <= in_d;
            data_q     <= data_d;
            // Tracks the two-cycle RAM read latency per issued lane.
            rd1_v_q    <= ram_rden;
            rd1_lane_q <= lane_q;
            rd2_v_q    <= rd1_v_q;
            rd2_lane_q <= rd1_lane_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        lane_d      = lane_q;
        in_d        = in_q;
        data_d      = data_q;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        ram_address = '0;
        ram_data    = '0;

        if (rd2_v_q) begin
            data_d[rd2_lane_q*MEM_WIDTH +: MEM_WIDTH] = ram_q;
        end

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    beat_d  = '0;
                    lane_d  = '0;
                    state_d = cmd_load ? LD_ACCEPT : UL_READ;
                end
            end
            LD_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_d    = in_data;
                    lane_d  = '0;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                ram_wren    = 1'b1;
                ram_address = word_a;
                ram_data    = in_q[lane_q*MEM_WIDTH +: MEM_WIDTH];
                if (lane_q == LAST_LANE) begin
                    lane_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = LD_GUARD;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = LD_ACCEPT;
                    end
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            LD_GUARD: begin
                ram_wren    = 1'b1;
                ram_address = GUARD_A;
                state_d     = DONE;
            end
            UL_READ: begin
                ram_rden    = 1'b1;
                ram_address = word_a;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = UL_WAIT;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            UL_WAIT: begin
                // Lane counter doubles as the drain counter here.
                if (lane_q == LW'(1)) begin
                    lane_d  = '0;
                    state_d = UL_OUT;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            UL_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = UL_READ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/int_ram_stream.md
# int_ram_stream

Bus-width streaming front end for one operand RAM of the RSA datapath. It loads a 1024-bit operand from a 32-bit valid/ready stream into the byte-wide operand RAM, and zeroes the guard word. It also unloads the RAM back onto a 32-bit stream. It drives RAM port 1 only. The arithmetic core owns port 2 and must not access the RAM while `busy` is high.

## Interface
- `MEM_WIDTH`, 8: RAM word width in bits.
- `MEM_WORDS`, 129: RAM depth. Words 0..MEM_WORDS-2 hold operand bytes; word MEM_WORDS-1 is the guard/carry byte.
- `BUS_WIDTH`, 32: stream width. LANES = BUS_WIDTH/MEM_WIDTH. BEATS = (MEM_WORDS-1)/LANES.

- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_load` in 1: 1 selects load, 0 selects unload. Sampled on the command handshake.
- `in_data` in BUS_WIDTH: load data. Little-endian; bits [7:0] are the lowest address.
- `in_valid` in 1: load data valid.
- `in_ready` out 1: load data ready.
- `out_data` out BUS_WIDTH: unload data, same byte order as load.
- `out_valid` out 1: unload data valid.
- `out_ready` in 1: unload data ready.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a command completes.
- `ram_address` out $clog2(MEM_WORDS): RAM port 1 address.
- `ram_data` out MEM_WIDTH: RAM port 1 write data.
- `ram_wren` out 1: RAM port 1 write enable.
- `ram_rden` out 1: RAM port 1 read enable.
- `ram_q` in MEM_WIDTH: RAM port 1 read data. Address and output are both registered, so read data is valid 2 cycles after `ram_rden`.

## Operation
- FSM states: IDLE, LD_ACCEPT, LD_WRITE, LD_GUARD, UL_READ, UL_WAIT, UL_OUT, DONE.
- Counters:
  - `beat`: 0..BEATS-1.
  - `lane`: 0..LANES-1.
  - RAM address = beat*LANES + lane.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: clear the counters and go to LD_ACCEPT (load) or UL_READ (unload).
- LD_ACCEPT:
  - `in_ready`=1.
  - On `in_valid`: latch `in_data` and go to LD_WRITE.
- LD_WRITE:
  - One byte per cycle: `ram_wren`=1, `ram_data`=latched byte[lane].
  - After lane LANES-1: go to LD_GUARD if this was the last beat, otherwise increment `beat` and return to LD_ACCEPT.
- LD_GUARD: one cycle writing 0 to address MEM_WORDS-1, then go to DONE.
- UL_READ:
  - LANES cycles with `ram_rden`=1.
  - `ram_q` captured into lane k in the cycle 2 after issue k.
  - Then go to UL_WAIT.
- UL_WAIT: 2 cycles, capturing the remaining lanes, then go to UL_OUT.
- UL_OUT:
  - `out_valid`=1 and `out_data` held stable until `out_ready`.
  - On handshake: go to DONE if this was the last beat, otherwise increment `beat` and go to UL_READ.
- The guard byte is never unloaded.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `ram_wren` and `ram_rden` are never high together. Both are 0 outside LD_WRITE, LD_GUARD and UL_READ.
- Commands are not accepted while busy (`cmd_ready`=0). No queuing.

## Timing
- Reset: state IDLE. All counters 0. Reset values of outputs:
  - `cmd_ready`=1.
  - `in_ready`, `out_valid`, `busy`, `done`, `ram_wren`, `ram_rden`=0.
  - `ram_address`, `ram_data`, `out_data`=0.
- Reset mid-command: returns to IDLE next cycle. RAM contents are left partially written. No `done`.
- RAM control outputs are decoded from registered state and counters. The write takes effect at the edge ending the LD_WRITE cycle.
- Load latency with `in_valid` held high:
  - Each beat takes 1 + LANES cycles.
  - Total from the command handshake to `done` = BEATS*(1+LANES) + 2 = 162 cycles for the defaults.
- Unload latency with `out_ready` held high:
  - Each beat takes LANES + 2 + 1 cycles.
  - Total = BEATS*7 + 1 = 225 cycles.
- Backpressure: `in_valid` or `out_ready` low stalls in LD_ACCEPT or UL_OUT indefinitely. No other state stalls.
- Last-beat wrap: `beat` does not roll over; the terminal beat exits to LD_GUARD or DONE.

## Structure
- Package `rsa_mem_pkg` holds:
  - the state enum `stream_state_t`;
  - default constants OP_BYTES=128, RAM_WORDS=129, BUS_W=32, MEM_W=8.
- Elaboration-time check: BUS_WIDTH % MEM_WIDTH == 0 and (MEM_WORDS-1) % LANES == 0.
- Single module. No sub-module. Top level instantiates it beside `int_ram` port 1.

## Test plan
- Load 32 beats `in_data`=32'h03020100 + beat*32'h04040404 → RAM[i]=i for i=0..127, RAM[128]=0, `done` at cycle 162.
- Load with `in_valid` toggling every other cycle → same RAM contents. No write occurs while in LD_ACCEPT.
- Unload after the first load, `out_ready`=1 → `out_data` beat n = {4n+3, 4n+2, 4n+1, 4n}, 32 beats, `done` at cycle 225.
- Unload with `out_ready` low for 10 cycles on beat 5 → `out_data`=32'h17161514 held stable, no extra `ram_rden`.
- Assert `rst` at LD_WRITE lane 2 of beat 7 → IDLE next cycle, `busy`=0, no `done`. A new load completes normally.
- `cmd_valid` pulsed while busy → ignored, `cmd_ready`=0. Exactly one `done` per accepted command.
